// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache between a
// 16-bit word-addressed load/store port and a 64-bit-line data memory.
// Hits complete with no wait states. A miss stalls the core. A dirty victim
// line is written back first, then the missing line is filled, and the access
// then completes from the cache.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_cpu_addr        word address; [12:0] used, [1:0] select word in line
//   i_cpu_re/i_cpu_we load / store request (both high = store)
//   i_cpu_wdata       store data
//   o_cpu_rdata       selected word of the indexed line (combinational)
//   o_cpu_stall       core must hold its request while high
//   o_mem_addr        line address {tag, index}
//   o_mem_re/o_mem_we one-cycle memory read / write request pulses
//   o_mem_wdata       write-back line, word 0 at [15:0]
//   i_mem_rd_data     fill line, valid with i_mem_rdy during a fill
//   i_mem_rdy         memory completion strobe (only trusted in wait states)
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_re,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  output logic [10:0] o_mem_addr,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rd_data,
  input  logic        i_mem_rdy
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 11 - INDEX_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbWait,
    StFillReq,
    StFillWait
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Line storage: data and tag are not reset, valid/dirty are.
  logic [63:0]         r_data  [LINES];
  logic [TAG_BITS-1:0] r_tag   [LINES];
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;

  // Line address of the missing request, held for the whole miss sequence.
  logic [10:0] r_req_line;

  // Address decode of the live CPU request.
  logic [1:0]            w_word;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_unused_addr_hi;

  // Decode of the latched miss line.
  logic [INDEX_BITS-1:0] w_req_index;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic [10:0]           w_victim_line;

  // Array update strobes from the FSM.
  logic w_latch;
  logic w_store_hit;
  logic w_wb_done;
  logic w_fill_done;

  assign w_word           = i_cpu_addr[1:0];
  assign w_index          = i_cpu_addr[INDEX_BITS+1:2];
  assign w_tag            = i_cpu_addr[12:INDEX_BITS+2];
  assign w_unused_addr_hi = ^i_cpu_addr[15:13];
  assign w_req            = i_cpu_re | i_cpu_we;
  assign w_hit            = r_valid[w_index] & (r_tag[w_index] == w_tag);

  assign w_req_index   = r_req_line[INDEX_BITS-1:0];
  assign w_req_tag     = r_req_line[10:INDEX_BITS];
  assign w_victim_line = {r_tag[w_req_index], w_req_index};

  // Read data ignores hit state; the core only uses it when not stalled.
  assign o_cpu_rdata = r_data[w_index][{w_word, 4'b0000} +: 16];
  assign o_cpu_stall = w_req & ((r_state != StIdle) | ~w_hit);

  always_comb begin
    w_state_nxt = r_state;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    w_latch     = 1'b0;
    w_store_hit = 1'b0;
    w_wb_done   = 1'b0;
    w_fill_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_hit) begin
            w_store_hit = i_cpu_we;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = (r_valid[w_index] & r_dirty[w_index]) ? StWbReq : StFillReq;
          end
        end
      end
      StWbReq: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = w_victim_line;
        o_mem_wdata = r_data[w_req_index];
        w_state_nxt = StWbWait;
      end
      StWbWait: begin
        // The victim line cannot change while waiting, so address/data stay stable.
        o_mem_addr  = w_victim_line;
        o_mem_wdata = r_data[w_req_index];
        if (i_mem_rdy) begin
          w_wb_done   = 1'b1;
          w_state_nxt = StFillReq;
        end
      end
      StFillReq: begin
        o_mem_re    = 1'b1;
        o_mem_addr  = r_req_line;
        w_state_nxt = StFillWait;
      end
      StFillWait: begin
        o_mem_addr = r_req_line;
        if (i_mem_rdy) begin
          w_fill_done = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_req_line <= '0;
      r_valid    <= '0;
      r_dirty    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_req_line <= {w_tag, w_index};
      end
      if (w_store_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_wb_done) begin
        r_dirty[w_req_index] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[w_req_index] <= 1'b1;
        r_dirty[w_req_index] <= 1'b0;
      end
    end
  end

  // Store hits and fills happen in different states, so they never collide.
  always_ff @(posedge clk) begin
    if (w_store_hit) begin
      r_data[w_index][{w_word, 4'b0000} +: 16] <= i_cpu_wdata;
    end
    if (w_fill_done) begin
      r_data[w_req_index] <= i_mem_rd_data;
      r_tag[w_req_index]  <= w_req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [10:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rd_data;
  logic        mem_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_ctrl #(.INDEX_BITS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_re     (cpu_re),
    .i_cpu_we     (cpu_we),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_stall  (cpu_stall),
    .o_mem_addr   (mem_addr),
    .o_mem_re     (mem_re),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rd_data(mem_rd_data),
    .i_mem_rdy    (mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content pattern: word w of line L = (4*L + w) ^ 0x5A00.
  function automatic logic [15:0] mword(input logic [10:0] line, input int w);
    return (({5'b0, line} * 16'd4) + 16'(w)) ^ 16'h5A00;
  endfunction

  function automatic logic [63:0] mline(input logic [10:0] line);
    return {mword(line, 3), mword(line, 2), mword(line, 1), mword(line, 0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complete a pending memory transaction with a one-cycle mem_rdy pulse.
  task automatic mem_done(input logic [63:0] data);
    mem_rdy     = 1'b1;
    mem_rd_data = data;
    step();
    mem_rdy     = 1'b0;
    mem_rd_data = '0;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    cpu_addr    = '0;
    cpu_re      = 1'b0;
    cpu_we      = 1'b0;
    cpu_wdata   = '0;
    mem_rd_data = '0;
    mem_rdy     = 1'b0;
    step();
    step();
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    step();

    // Cold load miss to 0x0005: fill of line 0x001.
    cpu_addr = 16'h0005;
    cpu_re   = 1'b1;
    #1;
    chk("miss1_stall", 64'(cpu_stall), 64'd1);
    chk("miss1_idle_re", 64'(mem_re), 64'd0);
    step();
    chk("miss1_mem_re", 64'(mem_re), 64'd1);
    chk("miss1_mem_addr", 64'(mem_addr), 64'h001);
    chk("miss1_mem_we", 64'(mem_we), 64'd0);
    step();
    chk("miss1_re_pulse", 64'(mem_re), 64'd0);
    chk("miss1_wait_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("miss1_re_low2", 64'(mem_re), 64'd0);
    mem_done(mline(11'h001));
    chk("miss1_done_stall", 64'(cpu_stall), 64'd0);
    chk("miss1_rdata", 64'(cpu_rdata), 64'h5A05);

    // Load hit 0x0006.
    cpu_addr = 16'h0006;
    #1;
    chk("hit_stall", 64'(cpu_stall), 64'd0);
    chk("hit_rdata", 64'(cpu_rdata), 64'h5A06);
    step();
    chk("hit_no_re", 64'(mem_re), 64'd0);

    // Store hit 0xBEEF to 0x0004.
    cpu_re    = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0004;
    cpu_wdata = 16'hBEEF;
    #1;
    chk("st_hit_stall", 64'(cpu_stall), 64'd0);
    step();
    chk("st_hit_no_we", 64'(mem_we), 64'd0);
    cpu_we = 1'b0;
    cpu_re = 1'b1;
    #1;
    chk("ld_after_st", 64'(cpu_rdata), 64'hBEEF);
    cpu_addr = 16'h0005;
    #1;
    chk("ld_neighbour", 64'(cpu_rdata), 64'h5A05);

    // Load 0x0024: conflicts with dirty line 1, write-back then fill of 0x009.
    cpu_addr = 16'h0024;
    #1;
    chk("wb_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("wb_mem_we", 64'(mem_we), 64'd1);
    chk("wb_mem_re", 64'(mem_re), 64'd0);
    chk("wb_mem_addr", 64'(mem_addr), 64'h001);
    chk("wb_mem_wdata", mem_wdata, 64'h5A07_5A06_5A05_BEEF);
    step();
    chk("wb_we_pulse", 64'(mem_we), 64'd0);
    chk("wb_hold_addr", 64'(mem_addr), 64'h001);
    chk("wb_hold_w0", 64'(mem_wdata[15:0]), 64'hBEEF);
    step();
    chk("wb_hold_addr2", 64'(mem_addr), 64'h001);
    mem_done(64'd0);
    chk("wbf_mem_re", 64'(mem_re), 64'd1);
    chk("wbf_mem_addr", 64'(mem_addr), 64'h009);
    chk("wbf_mem_we", 64'(mem_we), 64'd0);
    step();
    mem_done(mline(11'h009));
    chk("wbf_stall", 64'(cpu_stall), 64'd0);
    chk("wbf_rdata", 64'(cpu_rdata), 64'h5A24);

    // Store miss to clean line: 0x0103 -> fill line 0x040, merge word 3.
    cpu_re    = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0103;
    cpu_wdata = 16'h1234;
    #1;
    chk("stm_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("stm_mem_re", 64'(mem_re), 64'd1);
    chk("stm_mem_addr", 64'(mem_addr), 64'h040);
    chk("stm_mem_we", 64'(mem_we), 64'd0);
    step();
    mem_done(mline(11'h040));
    chk("stm_done_stall", 64'(cpu_stall), 64'd0);
    step();
    chk("stm_no_we", 64'(mem_we), 64'd0);
    cpu_we = 1'b0;
    cpu_re = 1'b1;
    #1;
    chk("stm_merged", 64'(cpu_rdata), 64'h1234);
    cpu_addr = 16'h0102;
    #1;
    chk("stm_filled_w2", 64'(cpu_rdata), 64'h5B02);

    // Evict line 0x040 with load 0x0003; the merged store must be written back.
    cpu_addr = 16'h0003;
    #1;
    chk("ev_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("ev_mem_we", 64'(mem_we), 64'd1);
    chk("ev_mem_addr", 64'(mem_addr), 64'h040);
    chk("ev_mem_wdata", mem_wdata, 64'h1234_5B02_5B01_5B00);
    step();
    mem_done(64'd0);
    chk("ev_fill_addr", 64'(mem_addr), 64'h000);
    step();
    mem_done(mline(11'h000));
    chk("ev_rdata", 64'(cpu_rdata), 64'h5A03);

    // Reset during FILL_WAIT for 0x0044 (line 0x011).
    cpu_addr = 16'h0044;
    #1;
    chk("rfw_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("rfw_mem_re", 64'(mem_re), 64'd1);
    chk("rfw_mem_addr", 64'(mem_addr), 64'h011);
    step();
    rst_n = 1'b0;
    #1;
    chk("rfw_rst_re", 64'(mem_re), 64'd0);
    chk("rfw_rst_we", 64'(mem_we), 64'd0);
    chk("rfw_rst_addr", 64'(mem_addr), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rfw_remiss_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("rfw_refill_re", 64'(mem_re), 64'd1);
    chk("rfw_refill_addr", 64'(mem_addr), 64'h011);
    step();
    mem_done(mline(11'h011));
    chk("rfw_final_stall", 64'(cpu_stall), 64'd0);
    chk("rfw_final_rdata", 64'(cpu_rdata), 64'h5A44);

    cpu_re = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core's 16-bit load/store port and the 64-bit-line system data memory.
- Hits complete in zero wait states.
- Misses stall the core. A dirty victim line is written back first, then the missing line is filled, and the access completes from the cache.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines of 4x16-bit words); tag width is 11-INDEX_BITS.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cpu_addr  input  16  word address; bits [12:0] used, [1:0] select the word within a line, [15:13] ignored
- cpu_re  input  1  load request
- cpu_we  input  1  store request
- cpu_wdata  input  16  store data
- cpu_rdata  output  16  load data, valid when cpu_re=1 and cpu_stall=0
- cpu_stall  output  1  core must hold its request stable while high
- mem_addr  output  11  line address to memory
- mem_re  output  1  memory read request, one-cycle pulse
- mem_we  output  1  memory write request, one-cycle pulse
- mem_wdata  output  64  write-back line, word 0 at [15:0]
- mem_rd_data  input  64  fill line, valid in the cycle mem_rdy rises after a read request
- mem_rdy  input  1  memory idle or completing; high during the completion cycle

Behaviour:
- Address split: word=cpu_addr[1:0], index=cpu_addr[INDEX_BITS+1:2], tag=cpu_addr[12:INDEX_BITS+2].
- Line address = {tag,index}. Word w occupies bits [16w+15:16w].
- Storage: per line, data (64), tag, valid, dirty.
  - valid and dirty clear on reset; data and tag are not reset.
- hit = valid[index] & (tag_arr[index]==tag).
- cpu_rdata is combinational: selected word of data[index], whatever the hit state.
- cpu_stall = (cpu_re|cpu_we) & (state!=IDLE | ~hit).
- If cpu_re and cpu_we are both high, treat the access as a store; cpu_rdata still shows the old word.
- Store hit: on the clock edge, write cpu_wdata into the selected word and set dirty[index]. No memory traffic.
- States: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
  - IDLE: on a request with ~hit, latch the request line address. If the victim is valid & dirty go to WB_REQ, else FILL_REQ.
  - WB_REQ:
    - drive mem_we=1, mem_addr={tag_arr[index],index}, mem_wdata=data[index];
    - go to WB_WAIT next cycle.
  - WB_WAIT:
    - hold mem_addr and mem_wdata stable, mem_we=0;
    - on mem_rdy=1 clear dirty[index] and go to FILL_REQ.
  - FILL_REQ: drive mem_re=1, mem_addr={tag,index}; go to FILL_WAIT.
  - FILL_WAIT:
    - mem_re=0;
    - on mem_rdy=1 write mem_rd_data into data[index], set tag_arr[index]=tag, valid=1, dirty=0;
    - go to IDLE.
  - In IDLE the held request now hits: the load returns, or the store merges and sets dirty, and stall drops that cycle.
- Never assert mem_re/mem_we for more than one cycle per transaction. Never issue a request while a transaction is outstanding.
- mem_rdy is ignored in IDLE, WB_REQ and FILL_REQ.
- Memory latency is arbitrary (at least 1 cycle); only mem_rdy is trusted.
- Outputs in IDLE: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset values: state IDLE, mem_re=0, mem_we=0, all valid/dirty=0; cpu_stall follows its equation (low with no request).
- Reset mid-transaction: return to IDLE immediately and drop the fill/write-back with no array update. The memory shares rst_n.
- Requests with cpu_re=cpu_we=0 never change state or arrays.

Test Plan:
- After reset, load cpu_addr=0x0005 -> stall high; one mem_re pulse with mem_addr=0x001; no mem_we; after mem_rdy, cpu_rdata = bits [31:16] of the returned line, stall low.
- Repeat load 0x0006 right after -> hit, stall low in the same cycle, no memory request.
- Store 0xBEEF to 0x0004 (hit) -> zero stall, dirty set. Load 0x0004 -> 0xBEEF.
- Load 0x0024 (same index 1, tag differs) with line 1 dirty -> mem_we pulse with mem_addr=0x001 and bits [15:0]=0xBEEF held until mem_rdy. Then mem_re pulse with mem_addr=0x009, then hit.
- Store miss to clean line at 0x0103 -> fill of line 0x040, then word 3 merged, dirty set, zero mem_we until that line is evicted.
- Assert rst_n=0 during FILL_WAIT -> state IDLE, mem_re/mem_we low, a subsequent load to the same address misses again.
